// File: rtl/goldschmidt_ctrl.sv
// goldschmidt_ctrl: sequencer for the two-stage Goldschmidt divider datapath.
// Accepts a divide request, issues D/N operand pairs with the K select,
// forwards rounded products back as operands and captures the quotient.
// Optional feature macro: GOLDSCHMIDT_DIVZERO_EN (short-cuts D_in == 0 to a
// saturated quotient with the dz flag set).
module goldschmidt_ctrl #(
    parameter int unsigned ITERS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] N_in,
    input  logic [15:0] D_in,
    input  logic [15:0] IA_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] Q,
    output logic        dz,
    output logic [15:0] dp_N,
    output logic [15:0] dp_D,
    output logic [15:0] dp_IA,
    output logic        kSelect,
    output logic        ndSelect,
    input  logic [31:0] dp_result
);

    localparam int unsigned DW = 16;
    localparam int unsigned PW = 32;
    localparam int unsigned IW = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_D = 3'd1,
        ISSUE_N = 3'd2,
        DRAIN   = 3'd3,
        CAPTURE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   iter_q, iter_d;
    logic [DW-1:0]   n_q, n_d;
    logic [DW-1:0]   d_q, d_d;
    logic [DW-1:0]   ia_q, ia_d;
    logic [DW-1:0]   q_q, q_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [DW-1:0]   rne_c;
    logic [DW-1:0]   dp_n_c, dp_d_c;
    logic            ksel_c, ndsel_c;
`ifdef GOLDSCHMIDT_DIVZERO_EN
    logic            dzp_q, dzp_d;
    logic            dz_q, dz_d;
`endif

    // Round a Q2.30 product to Q1.15, nearest-even, saturating on overflow.
    function automatic logic [DW-1:0] rne(input logic [PW-1:0] p);
        logic [DW:0] s;
        s = {1'b0, p[30:15]} + (DW+1)'(p[14] & (p[15] | (p[13:0] != 14'd0)));
        return (p[31] | s[DW]) ? {DW{1'b1}} : s[DW-1:0];
    endfunction

    // Rounded datapath product, forwarded as the next operand.
    always_comb rne_c = rne(dp_result);

    // Next-state, operand forwarding and datapath select generation.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        n_d     = n_q;
        d_d     = d_q;
        ia_d    = ia_q;
        q_d     = q_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dp_n_c  = n_q;
        dp_d_c  = d_q;
        ksel_c  = 1'b0;
        ndsel_c = 1'b1;
`ifdef GOLDSCHMIDT_DIVZERO_EN
        dzp_d   = dzp_q;
        dz_d    = dz_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d     = N_in;
                    d_d     = D_in;
                    ia_d    = IA_in;
                    iter_d  = '0;
                    busy_d  = 1'b1;
                    state_d = ISSUE_D;
`ifdef GOLDSCHMIDT_DIVZERO_EN
                    dzp_d   = (D_in == '0);
                    if (D_in == '0) begin
                        state_d = CAPTURE;
                    end
`endif
                end
            end
            ISSUE_D: begin
                ndsel_c = 1'b0;
                ksel_c  = (iter_q != '0);
                if (iter_q != '0) begin
                    dp_d_c = rne_c;
                end
                d_d     = dp_d_c;
                state_d = ISSUE_N;
            end
            ISSUE_N: begin
                if (iter_q != '0) begin
                    dp_n_c = rne_c;
                end
                n_d = dp_n_c;
                if (iter_q == IW'(ITERS - 1)) begin
                    state_d = DRAIN;
                end else begin
                    iter_d  = iter_q + IW'(1);
                    state_d = ISSUE_D;
                end
            end
            DRAIN: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                q_d     = rne_c;
`ifdef GOLDSCHMIDT_DIVZERO_EN
                if (dzp_q) begin
                    q_d = {DW{1'b1}};
                end
                dz_d    = dzp_q;
`endif
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and operand registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            iter_q  <= '0;
            n_q     <= '0;
            d_q     <= '0;
            ia_q    <= '0;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            n_q     <= n_d;
            d_q     <= d_d;
            ia_q    <= ia_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef GOLDSCHMIDT_DIVZERO_EN
    // Divide-by-zero pending flag and reported flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dzp_q <= 1'b0;
            dz_q  <= 1'b0;
        end else begin
            dzp_q <= dzp_d;
            dz_q  <= dz_d;
        end
    end
    assign dz = dz_q;
`else
    assign dz = 1'b0;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign Q        = q_q;
    assign dp_N     = dp_n_c;
    assign dp_D     = dp_d_c;
    assign dp_IA    = ia_q;
    assign kSelect  = ksel_c;
    assign ndSelect = ndsel_c;

endmodule

// File: doc/goldschmidt_ctrl.md
# goldschmidt_ctrl

Control unit for the Goldschmidt divider datapath. It accepts a divide request and holds the operands. It sequences `kSelect`/`ndSelect` so the two-stage datapath multiplies D then N by each iteration factor K. It forwards the rounded products back as the next operands and captures the final quotient. It sits between the issuing unit (start/done handshake) and the datapath (`N`, `D`, `IA`, `result`).

## Interface
- `ITERS`, default 3: number of D/N multiply pairs, including the initial IA pair; legal range 1–15.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request strobe; sampled only in IDLE.
- `N_in` in 16: dividend, unsigned Q1.15.
- `D_in` in 16: divisor, unsigned Q1.15.
- `IA_in` in 16: initial reciprocal approximation, unsigned Q1.15.
- `busy` out 1: high from the cycle after `start` is accepted until `done` rises.
- `done` out 1: one-cycle pulse; `Q` is valid from this cycle on.
- `Q` out 16: quotient, Q1.15; held until the next capture.
- `dz` out 1: divide-by-zero flag, valid with `done`.
- `dp_N` out 16: datapath N operand.
- `dp_D` out 16: datapath D operand.
- `dp_IA` out 16: datapath IA operand.
- `kSelect` out 1: 0 selects K=IA; 1 selects K = 2 − rounded(previous D product).
- `ndSelect` out 1: 0 issues D and loads K; 1 issues N and holds K.
- `dp_result` in 32: datapath registered product, Q2.30.

## Operation
- **States:** IDLE, ISSUE_D, ISSUE_N, DRAIN, CAPTURE.
- **IDLE:**
  - Outputs `kSelect`=0, `ndSelect`=1.
  - On `start`=1: latch `N_in`, `D_in` and `IA_in` into N_r, D_r and IA_r; clear the iteration counter; go to ISSUE_D.
- **ISSUE_D:**
  - Drive `ndSelect`=0.
  - Drive `kSelect` = (iter≠0).
  - `dp_D` = D_r when iter=0, otherwise RNE(`dp_result`), forwarded combinationally. The forwarded value is also written to D_r.
  - Next state is ISSUE_N.
- **ISSUE_N:**
  - Drive `ndSelect`=1.
  - `dp_N` = N_r when iter=0, otherwise RNE(`dp_result`), forwarded combinationally. The forwarded value is also written to N_r.
  - If iter = ITERS−1, go to DRAIN; otherwise iter++ and go to ISSUE_D.
- **DRAIN:** `dp_result` holds the last D product; it is ignored. Next state is CAPTURE.
- **CAPTURE:**
  - `Q` ← RNE(`dp_result`), the last N product.
  - Assert `done` in the following cycle; return to IDLE.
- **RNE rule:** P = `dp_result`.
  - r = P[30:15] + (P[14] & (P[15] | (P[13:0]≠0))).
  - If P[31]=1 or the add carries out, r = 0xFFFF (saturate).
- `dp_IA` = IA_r at all times.
- `start` while busy is ignored; it is neither queued nor an error.
- `start` and `done` in the same cycle: `start` is accepted, since the block is already in IDLE.

## Timing
- **Reset values:**
  - `busy`, `done`, `dz` = 0.
  - `Q`, `dp_N`, `dp_D`, `dp_IA` = 0.
  - `kSelect` = 0, `ndSelect` = 1.
  - State = IDLE; iter = 0.
- **Iteration issue:** one ISSUE_D/ISSUE_N pair per 2 cycles, back-to-back. The D product of a pair is on `dp_result` in the next pair's ISSUE_D; its N product is there in the next ISSUE_N.
- **Latency:** with `start` sampled in cycle 0, `done` is high in cycle 2·ITERS+3. For ITERS=3, `done` is in cycle 9.
- **Reset mid-operation:** immediate return to IDLE with reset values. No `done` is issued, and `Q` is cleared.

## Configuration
- Macro: `GOLDSCHMIDT_DIVZERO_EN`.
- **Defined:** `start` with `D_in`=0 skips iteration. The FSM goes IDLE→CAPTURE, and `done` follows two cycles after `start` with `Q`=0xFFFF and `dz`=1. No datapath issue occurs: `ndSelect` stays 1 and `kSelect` stays 0.
- **Undefined:** `dz` is tied to 0, and D=0 runs the normal sequence; the result is unspecified but saturating.

## Test plan
- **Reset values:** assert `reset`=0 mid-ISSUE_N of iteration 1, then release → all outputs at reset values; the next `start` completes normally with correct latency.
- **Unit divisor:** N=0x4000, D=0x8000, IA=0x8000, ITERS=3 → `done` exactly 9 cycles after `start`; `Q`=0x4000 exactly.
- **General divide:** N=0x4000, D=0x6000, IA=0xAAAB → `Q` within ±1 lsb of 0x5555. `kSelect` sequence over the ISSUE_D cycles is 0,1,1; `ndSelect` alternates 0,1 during the six issue cycles.
- **Busy and back-to-back start:** `start` pulsed during `busy` → ignored; `Q` and latency unchanged. `start` held high at `done` → second operation accepted in that cycle.
- **Saturation:** `dp_result` forced to 0x8000_0000 in CAPTURE → `Q`=0xFFFF. Forced to 0x0000_C000 → r=0x0002 (tie rounded to even); 0x0000_4000 → r=0x0000.
- **Divide-by-zero (`GOLDSCHMIDT_DIVZERO_EN` defined):** D_in=0 → `done` two cycles after `start`, `Q`=0xFFFF, `dz`=1, `ndSelect` never 0. Without the macro → `dz` stays 0.
